// File: rtl/energy_accumulator.sv
// Epoch energy accumulator: sums NUM_ROWS partial sums per epoch and presents the total on valid/ready.
// Optional running-minimum tracker enabled by defining ENERGY_MIN_TRACK_EN.
module energy_accumulator #(
   parameter int IN_WIDTH  = 16,
   parameter int NUM_ROWS  = 256,
   parameter int ACC_WIDTH = IN_WIDTH + $clog2(NUM_ROWS),
   parameter int CNT_WIDTH = $clog2(NUM_ROWS) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 start_i,
   input  logic [IN_WIDTH-1:0]  sum_i,
   input  logic                 sum_valid_i,
   output logic [ACC_WIDTH-1:0] energy_o,
   output logic                 energy_valid_o,
   input  logic                 energy_ready_i,
   output logic                 busy_o,
   output logic                 overrun_o,
   output logic [ACC_WIDTH-1:0] min_energy_o,
   output logic                 min_update_o
);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_HOLD} state_t;

   state_t               state_q, state_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] energy_q, energy_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 overrun_q, overrun_d;
   logic                 accept;
   logic                 last_row;
   logic [ACC_WIDTH-1:0] acc_sum;

   assign accept   = en_i & sum_valid_i;
   assign last_row = (cnt_q == CNT_WIDTH'(NUM_ROWS - 1));
   assign acc_sum  = acc_q + ACC_WIDTH'(sum_i);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      energy_d  = energy_q;
      overrun_d = overrun_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               acc_d     = '0;
               cnt_d     = '0;
               overrun_d = 1'b0;
               state_d   = S_ACCUM;
            end else if (accept) begin
               overrun_d = 1'b1;
            end
         end
         S_ACCUM: begin
            // A restart wins over a sample arriving in the same cycle.
            if (start_i) begin
               acc_d     = '0;
               cnt_d     = '0;
               overrun_d = 1'b0;
            end else if (accept) begin
               acc_d = acc_sum;
               cnt_d = cnt_q + CNT_WIDTH'(1);
               if (last_row) begin
                  energy_d = acc_sum;
                  state_d  = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (accept) begin
               overrun_d = 1'b1;
            end
            if (energy_ready_i) begin
               if (start_i) begin
                  acc_d     = '0;
                  cnt_d     = '0;
                  overrun_d = 1'b0;
                  state_d   = S_ACCUM;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         cnt_q     <= '0;
         energy_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         energy_q  <= energy_d;
         overrun_q <= overrun_d;
      end
   end

   assign energy_o       = energy_q;
   assign energy_valid_o = (state_q == S_HOLD);
   assign busy_o         = (state_q == S_ACCUM);
   assign overrun_o      = overrun_q;

`ifdef ENERGY_MIN_TRACK_EN
   logic [ACC_WIDTH-1:0] min_q, min_d;
   logic                 min_upd_q, min_upd_d;

   // Evaluated only on the ACCUM->HOLD edge so the pulse lines up with the first valid cycle.
   always_comb begin
      min_d     = min_q;
      min_upd_d = 1'b0;
      if (state_q == S_ACCUM && state_d == S_HOLD && energy_d < min_q) begin
         min_d     = energy_d;
         min_upd_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         min_q     <= '1;
         min_upd_q <= 1'b0;
      end else begin
         min_q     <= min_d;
         min_upd_q <= min_upd_d;
      end
   end

   assign min_energy_o = min_q;
   assign min_update_o = min_upd_q;
`else
   assign min_energy_o = '1;
   assign min_update_o = 1'b0;
`endif

endmodule

// File: tb/tb_energy_accumulator.sv
// Bench for energy_accumulator (IN_WIDTH=16, NUM_ROWS=4): vector table, hand sequences, random vs model.
module tb_energy_accumulator;

   localparam int IN_W  = 16;
   localparam int ROWS  = 4;
   localparam int ACC_W = 18;
   localparam logic [ACC_W-1:0] ALL1 = '1;

   logic             clk = 1'b0;
   logic             rst, en, start, sum_valid, ready;
   logic [IN_W-1:0]  sum;
   logic [ACC_W-1:0] energy, min_energy;
   logic             energy_valid, busy, overrun, min_update;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   energy_accumulator #(.IN_WIDTH(IN_W), .NUM_ROWS(ROWS)) dut (
      .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start),
      .sum_i(sum), .sum_valid_i(sum_valid),
      .energy_o(energy), .energy_valid_o(energy_valid), .energy_ready_i(ready),
      .busy_o(busy), .overrun_o(overrun),
      .min_energy_o(min_energy), .min_update_o(min_update)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic s, input logic v, input logic r,
                        input logic [IN_W-1:0] d);
      en = e; start = s; sum_valid = v; ready = r; sum = d;
   endtask

   // ---------------- behavioural reference model ----------------
   localparam int M_IDLE = 0, M_ACCUM = 1, M_HOLD = 2;
   int               m_mode;
   int unsigned      m_rows[$];
   logic [ACC_W-1:0] m_energy, m_min;
   logic             m_ovr, m_upd;

   function automatic void model_reset();
      m_mode = M_IDLE; m_rows.delete(); m_energy = '0; m_ovr = 1'b0;
      m_min = ALL1; m_upd = 1'b0;
   endfunction

   function automatic void model_step(input logic e, input logic s, input logic v,
                                      input logic r, input logic [IN_W-1:0] d);
      bit take;
      int unsigned total;
      take  = e && v;
      m_upd = 1'b0;
      case (m_mode)
         M_IDLE: begin
            if (s) begin m_mode = M_ACCUM; m_rows.delete(); m_ovr = 1'b0; end
            else if (take) m_ovr = 1'b1;
         end
         M_ACCUM: begin
            if (s) begin m_rows.delete(); m_ovr = 1'b0; end
            else if (take) begin
               m_rows.push_back(d);
               if (m_rows.size() == ROWS) begin
                  total = 0;
                  foreach (m_rows[i]) total += m_rows[i];
                  m_energy = total[ACC_W-1:0];
                  m_mode = M_HOLD;
                  m_rows.delete();
`ifdef ENERGY_MIN_TRACK_EN
                  if (m_energy < m_min) begin m_min = m_energy; m_upd = 1'b1; end
`endif
               end
            end
         end
         default: begin
            if (take) m_ovr = 1'b1;
            if (r) begin
               if (s) begin m_mode = M_ACCUM; m_rows.delete(); m_ovr = 1'b0; end
               else m_mode = M_IDLE;
            end
         end
      endcase
   endfunction

   task automatic check_model();
      chk("rnd_valid", energy_valid, m_mode == M_HOLD);
      chk("rnd_busy", busy, m_mode == M_ACCUM);
      chk("rnd_overrun", overrun, m_ovr);
      chk("rnd_energy", energy, m_energy);
      chk("rnd_min", min_energy, m_min);
      chk("rnd_min_upd", min_update, m_upd);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      drive(0, 0, 0, 0, '0);
      repeat (n) tick();
      rst = 1'b0;
      model_reset();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic en, start, valid, ready;
      logic [IN_W-1:0]  sum;
      logic [ACC_W-1:0] energy;
      logic vld, bsy, ovr;
   } vec_t;

   function automatic vec_t mk(input logic e, input logic s, input logic v, input logic r,
                               input logic [IN_W-1:0] d, input logic [ACC_W-1:0] x,
                               input logic xv, input logic xb, input logic xo);
      vec_t t;
      t.en = e; t.start = s; t.valid = v; t.ready = r; t.sum = d;
      t.energy = x; t.vld = xv; t.bsy = xb; t.ovr = xo;
      return t;
   endfunction

   vec_t tbl[$];

   initial begin
      int totals[4] = '{100, 80, 90, 80};
`ifdef ENERGY_MIN_TRACK_EN
      int exp_min[4] = '{100, 80, 80, 80};
      bit exp_upd[4] = '{1, 1, 0, 0};
`else
      int exp_min[4] = '{262143, 262143, 262143, 262143};
      bit exp_upd[4] = '{0, 0, 0, 0};
`endif
      logic [IN_W-1:0] part;
      logic e, s, v, r;
      logic [IN_W-1:0] d;

      // basic epoch, hold stability, start ignored without ready
      tbl.push_back(mk(1,1,0,0,0,        0,0,1,0));
      tbl.push_back(mk(1,0,1,0,10,       0,0,1,0));
      tbl.push_back(mk(1,0,1,0,20,       0,0,1,0));
      tbl.push_back(mk(1,0,1,0,30,       0,0,1,0));
      tbl.push_back(mk(1,0,1,0,40,     100,1,0,0));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(1,0,0,0,0, 100,1,0,0));
      tbl.push_back(mk(1,1,0,0,0,      100,1,0,0));
      tbl.push_back(mk(1,0,0,1,0,      100,0,0,0));
      // gaps and en_i gating
      tbl.push_back(mk(1,1,0,0,0,      100,0,1,0));
      tbl.push_back(mk(1,0,1,0,5,      100,0,1,0));
      tbl.push_back(mk(1,0,0,0,0,      100,0,1,0));
      tbl.push_back(mk(0,0,1,0,99,     100,0,1,0));
      tbl.push_back(mk(1,0,1,0,5,      100,0,1,0));
      tbl.push_back(mk(1,0,1,0,5,      100,0,1,0));
      tbl.push_back(mk(1,0,1,0,5,       20,1,0,0));
      tbl.push_back(mk(1,0,0,1,0,       20,0,0,0));
      // width boundary
      tbl.push_back(mk(1,1,0,0,0,       20,0,1,0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,1,0,16'hFFFF, 20,0,1,0));
      tbl.push_back(mk(1,0,1,0,16'hFFFF, 18'h3FFFC,1,0,0));
      tbl.push_back(mk(1,0,0,1,0, 18'h3FFFC,0,0,0));
      // restart mid-epoch, same-cycle sample ignored
      tbl.push_back(mk(1,1,0,0,0, 18'h3FFFC,0,1,0));
      tbl.push_back(mk(1,0,1,0,7, 18'h3FFFC,0,1,0));
      tbl.push_back(mk(1,0,1,0,7, 18'h3FFFC,0,1,0));
      tbl.push_back(mk(1,1,1,0,50, 18'h3FFFC,0,1,0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,1,0,1, 18'h3FFFC,0,1,0));
      tbl.push_back(mk(1,0,1,0,1,        4,1,0,0));
      // overrun in HOLD, transfer + start back-to-back
      tbl.push_back(mk(1,0,1,0,9,        4,1,0,1));
      tbl.push_back(mk(1,1,0,1,0,        4,0,1,0));
      for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,1,0,2, 4,0,1,0));
      tbl.push_back(mk(1,0,1,0,2,        8,1,0,0));
      tbl.push_back(mk(1,0,0,1,0,        8,0,0,0));
      // overrun in IDLE, en_i gating, cleared by start
      tbl.push_back(mk(1,0,1,0,3,        8,0,0,1));
      tbl.push_back(mk(0,0,1,0,3,        8,0,0,1));
      tbl.push_back(mk(1,1,0,0,0,        8,0,1,0));

      rst = 1'b1;
      drive(0, 0, 0, 0, '0);

      // reset state
      do_reset(2);
      chk("rst_valid", energy_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_energy", energy, 0);
      chk("rst_min", min_energy, ALL1);
      chk("rst_min_upd", min_update, 0);

      // set overrun, then reset mid-epoch must clear everything
      drive(1, 0, 1, 0, 16'd3); tick();
      chk("pre_rst_overrun", overrun, 1);
      do_reset(2);
      chk("rst2_overrun", overrun, 0);
      drive(1, 1, 0, 0, '0); tick();
      drive(1, 0, 1, 0, 16'd11); tick();
      drive(1, 0, 1, 0, 16'd12); tick();
      chk("mid_busy", busy, 1);
      do_reset(2);
      chk("rst3_busy", busy, 0);
      chk("rst3_valid", energy_valid, 0);
      chk("rst3_min", min_energy, ALL1);
      // abort must have cleared the partial sum: a fresh epoch of 1s gives 4
      drive(1, 1, 0, 0, '0); tick();
      for (int i = 0; i < ROWS; i++) begin drive(1, 0, 1, 0, 16'd1); tick(); end
      chk("post_rst_energy", energy, 4);
      chk("post_rst_valid", energy_valid, 1);
      do_reset(1);

      // table-driven vectors
      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].start, tbl[i].valid, tbl[i].ready, tbl[i].sum);
         tick();
         $display("[TB] vec %0d en=%0d st=%0d v=%0d rdy=%0d sum=%0d -> energy=%0d valid=%0d busy=%0d ovr=%0d",
                  i, tbl[i].en, tbl[i].start, tbl[i].valid, tbl[i].ready, tbl[i].sum,
                  energy, energy_valid, busy, overrun);
         chk($sformatf("vec%0d_energy", i), energy, tbl[i].energy);
         chk($sformatf("vec%0d_valid", i), energy_valid, tbl[i].vld);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("vec%0d_overrun", i), overrun, tbl[i].ovr);
      end

      // minimum tracking across epochs
      do_reset(1);
      for (int k = 0; k < 4; k++) begin
         drive(1, 1, 0, 0, '0); tick();
         part = IN_W'(totals[k] / 4);
         for (int i = 0; i < 3; i++) begin drive(1, 0, 1, 0, part); tick(); end
         drive(1, 0, 1, 0, IN_W'(totals[k] - 3 * (totals[k] / 4))); tick();
         $display("[TB] epoch %0d energy=%0d min=%0d upd=%0d", k, energy, min_energy, min_update);
         chk($sformatf("min_ep%0d_energy", k), energy, totals[k]);
         chk($sformatf("min_ep%0d_value", k), min_energy, exp_min[k]);
         chk($sformatf("min_ep%0d_pulse", k), min_update, exp_upd[k]);
         drive(1, 0, 0, 1, '0); tick();
         chk($sformatf("min_ep%0d_pulse_end", k), min_update, 0);
      end

      // randomized stimulus against the reference model
      do_reset(1);
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 499) == 0) begin
            do_reset(1);
            check_model();
            continue;
         end
         e = ($urandom_range(0, 99) < 85);
         s = ($urandom_range(0, 99) < 6);
         v = ($urandom_range(0, 99) < 70);
         r = ($urandom_range(0, 99) < 30);
         d = ($urandom_range(0, 9) == 0) ? 16'hFFFF : IN_W'($urandom);
         if (m_mode == M_HOLD && r)
            $display("[TB] transfer cycle %0d energy=%0d restart=%0d", c, m_energy, s);
         drive(e, s, v, r, d);
         model_step(e, s, v, r, d);
         tick();
         check_model();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
